// File: rtl/uart_definitions.sv
// Shared UART definitions: receiver FSM encodings, frame width and bit-period derivation.
// Optional even parity is selected by UART_RX_PARITY_EN in the files that import this package.
package uart_definitions;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Clock cycles per serial bit, truncated; shared with the transmitter.
    function automatic int unsigned clks_per_bit(input int unsigned clock_frequency,
                                                 input int unsigned baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_byte_receiver_byte_fifo.sv
// byte_fifo: power-of-two circular buffer with registered head data/valid and full/empty flags.
// Independent of UART_RX_PARITY_EN; a push into an empty buffer appears on out_valid one cycle later.
module byte_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             pop_c;
    logic             do_push_c;
    logic             head_from_push_c;
    logic [PTR_W-1:0] rd_ptr_next_c;
    logic [CNT_W-1:0] count_next_c;

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign pop_c            = out_valid & out_ready;
    assign do_push_c        = push & (~full | pop_c);
    assign rd_ptr_next_c    = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
    assign count_next_c     = count + CNT_W'(do_push_c) - CNT_W'(pop_c);
    assign head_from_push_c = do_push_c && ((count - CNT_W'(pop_c)) == '0);

    always_ff @(posedge clock) begin
        if (do_push_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            full      <= 1'b0;
            empty     <= 1'b1;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_ptr_next_c;
            count     <= count_next_c;
            out_valid <= (count_next_c != '0);
            full      <= (count_next_c == CNT_W'(DEPTH));
            empty     <= (count_next_c == '0);
            // Head register only moves when the head entry changes, so it holds under back-pressure.
            if (count_next_c != '0) begin
                out_data <= head_from_push_c ? push_data : mem[rd_ptr_next_c];
            end
        end
    end

endmodule

// File: rtl/uart_byte_receiver.sv
// UART receive front end: 2-flop synchronizer, 8N1 deserializer (8E1 with UART_RX_PARITY_EN)
// and a byte FIFO on a valid/ready stream; parity_error is tied low unless UART_RX_PARITY_EN is defined.
module uart_byte_receiver
    import uart_definitions::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
    parameter int unsigned BAUD_RATE       = 115200,
    parameter int unsigned FIFO_DEPTH      = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      uart_receive,
    output logic [UART_DATA_BITS-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overflow,
    output logic                      framing_error,
    output logic                      parity_error
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF_LOAD    = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned FULL_LOAD    = CLKS_PER_BIT - 1;
    localparam int unsigned BIT_IDX_W    = $clog2(UART_DATA_BITS);

    logic                      sync_0;
    logic                      sync_1;
    logic                      line_prev;
    rx_state_t                 state;
    logic [CNT_W-1:0]          bit_cnt;
    logic [BIT_IDX_W-1:0]      bit_idx;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic                      fifo_full;
    logic                      fifo_empty;

    logic                      expire_c;
    logic                      fall_c;
    logic                      pop_c;
    logic                      stop_good_c;

    assign expire_c = (bit_cnt == '0);
    assign fall_c   = line_prev & ~sync_1;
    assign pop_c    = ~fifo_empty & out_ready;

`ifdef UART_RX_PARITY_EN
    logic parity_bad;

    assign stop_good_c = (state == ST_STOP) && expire_c && sync_1 && !parity_bad;
`else
    assign stop_good_c  = (state == ST_STOP) && expire_c && sync_1;
    assign parity_error = 1'b0;
`endif

    // Line synchronizer plus one delay flop for falling-edge detection; all idle high.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_0    <= 1'b1;
            sync_1    <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync_0    <= uart_receive;
            sync_1    <= sync_0;
            line_prev <= sync_1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            overflow      <= 1'b0;
            framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad    <= 1'b0;
            parity_error  <= 1'b0;
`endif
        end else begin
            framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
            if (stop_good_c && fifo_full && !pop_c) begin
                overflow <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (fall_c) begin
                        bit_cnt <= CNT_W'(HALF_LOAD);
                        state   <= ST_START;
                    end
                end

                // Mid-start-bit recheck rejects glitches shorter than half a bit.
                ST_START: begin
                    if (expire_c) begin
                        if (!sync_1) begin
                            bit_cnt <= CNT_W'(FULL_LOAD);
                            bit_idx <= '0;
                            state   <= ST_DATA;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (expire_c) begin
                        shift_reg <= {sync_1, shift_reg[UART_DATA_BITS-1:1]};
                        bit_cnt   <= CNT_W'(FULL_LOAD);
                        bit_idx   <= bit_idx + BIT_IDX_W'(1);
                        if (bit_idx == BIT_IDX_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                // Even parity: data plus parity bit must XOR to zero.
                ST_PARITY: begin
                    if (expire_c) begin
                        parity_bad   <= ^{shift_reg, sync_1};
                        parity_error <= ^{shift_reg, sync_1};
                        bit_cnt      <= CNT_W'(FULL_LOAD);
                        state        <= ST_STOP;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
`endif

                // Leave mid-stop-bit so a back-to-back start edge is not missed.
                ST_STOP: begin
                    if (expire_c) begin
                        if (!sync_1) begin
                            framing_error <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_byte_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (stop_good_c),
        .push_data (shift_reg),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver at 10 clocks per bit; parity scenario only with UART_RX_PARITY_EN.
module tb_uart_byte_receiver;

    localparam int unsigned CLOCK_FREQUENCY = 1_000_000;
    localparam int unsigned BAUD_RATE       = 100_000;
    localparam int unsigned FIFO_DEPTH      = 16;
    localparam int unsigned CPB             = 10;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    // Start-bit drive to stop sample: 2 sync flops + edge flop, half bit, then one bit per remaining sample.
    localparam int unsigned LAT = 3 + CPB / 2 + CPB * (FRAME_BITS - 1);

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_receive;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;
    logic       framing_error;
    logic       parity_error;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic [7:0]  rxq[$];
    int          valid_cnt = 0;
    int          fe_cnt = 0;
    int          pe_cnt = 0;
    int unsigned last_valid_cyc = 0;
    int unsigned last_fe_cyc = 0;
    int unsigned last_pe_cyc = 0;

    uart_byte_receiver #(
        .CLOCK_FREQUENCY (CLOCK_FREQUENCY),
        .BAUD_RATE       (BAUD_RATE),
        .FIFO_DEPTH      (FIFO_DEPTH)
    ) dut (
        .clock         (clk),
        .reset         (reset),
        .uart_receive  (uart_receive),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .overflow      (overflow),
        .framing_error (framing_error),
        .parity_error  (parity_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor on the falling edge: records delivered bytes and pulse counts.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
            end
            if (out_valid && out_ready) rxq.push_back(out_data);
            if (framing_error) begin
                fe_cnt++;
                last_fe_cyc = cyc;
            end
            if (parity_error) begin
                pe_cnt++;
                last_pe_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        uart_receive = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^data);
`endif
        send_bit(stop_bit);
    endtask

    task automatic test_reset();
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_framing_error: got %b expected 0", framing_error); end
        if (parity_error !== 1'b0) begin errors++; $display("FAIL reset_parity_error: got %b expected 0", parity_error); end
    endtask

    task automatic test_single_frame();
        int v0, f0, p0;
        int unsigned start;
        rxq.delete();
        v0 = valid_cnt; f0 = fe_cnt; p0 = pe_cnt;
        start = cyc;
        send_frame(8'hA5, 1'b1);
        tick(20);
        checks += 5;
        if (rxq.size() != 1 || rxq[0] !== 8'hA5) begin
            errors++; $display("FAIL single_byte: got %0d bytes first %h expected 1 byte a5", rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx);
        end
        if (valid_cnt - v0 != 1) begin errors++; $display("FAIL single_valid_cycles: got %0d expected 1", valid_cnt - v0); end
        if (last_valid_cyc - start != LAT) begin errors++; $display("FAIL single_latency: got %0d expected %0d", last_valid_cyc - start, LAT); end
        if (fe_cnt != f0) begin errors++; $display("FAIL single_framing: got %0d pulses expected 0", fe_cnt - f0); end
        if (pe_cnt != p0) begin errors++; $display("FAIL single_parity: got %0d pulses expected 0", pe_cnt - p0); end
    endtask

    task automatic test_glitch();
        int v0, f0;
        rxq.delete();
        v0 = valid_cnt; f0 = fe_cnt;
        uart_receive = 1'b0;
        tick(3);
        uart_receive = 1'b1;
        tick(30);
        checks += 2;
        if (valid_cnt != v0) begin errors++; $display("FAIL glitch_valid: got %0d cycles expected 0", valid_cnt - v0); end
        if (fe_cnt != f0) begin errors++; $display("FAIL glitch_framing: got %0d pulses expected 0", fe_cnt - f0); end
        send_frame(8'h5A, 1'b1);
        tick(20);
        checks++;
        if (rxq.size() != 1 || rxq[0] !== 8'h5A) begin
            errors++; $display("FAIL glitch_rearm: got %0d bytes first %h expected 1 byte 5a", rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx);
        end
    endtask

    task automatic test_framing();
        int v0, f0;
        int unsigned start;
        rxq.delete();
        v0 = valid_cnt; f0 = fe_cnt;
        start = cyc;
        send_frame(8'h3C, 1'b0);
        uart_receive = 1'b1;
        tick(30);
        checks += 3;
        if (fe_cnt - f0 != 1) begin errors++; $display("FAIL framing_pulse: got %0d cycles expected 1", fe_cnt - f0); end
        if (last_fe_cyc - start != LAT) begin errors++; $display("FAIL framing_latency: got %0d expected %0d", last_fe_cyc - start, LAT); end
        if (valid_cnt != v0) begin errors++; $display("FAIL framing_valid: got %0d cycles expected 0", valid_cnt - v0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'hC3;
        rxq.delete();
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
        tick(20);
        checks += 2;
        if (rxq.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", rxq.size()); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
        for (int i = 0; i < 3 && i < rxq.size(); i++) begin
            checks++;
            if (rxq[i] !== exp_b[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, rxq[i], exp_b[i]); end
        end
    endtask

    task automatic test_overflow();
        rxq.delete();
        out_ready = 1'b0;
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
        tick(10);
        checks += 3;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid_held: got %b expected 1", out_valid); end
        if (out_data !== 8'h00) begin errors++; $display("FAIL ovf_head_stable: got %h expected 00", out_data); end
        out_ready = 1'b1;
        tick(30);
        checks += 2;
        if (rxq.size() != 16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", rxq.size()); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        for (int i = 0; i < 16 && i < rxq.size(); i++) begin
            checks++;
            if (rxq[i] !== 8'(i)) begin errors++; $display("FAIL ovf_byte%0d: got %h expected %h", i, rxq[i], 8'(i)); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        int f0;
        d = 8'h55;
        rxq.delete();
        f0 = fe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        reset = 1'b1;
        for (int i = 3; i < 8; i++) send_bit(d[i]);
        send_bit(1'b1);
        tick(5);
        reset = 1'b0;
        tick(5);
        send_frame(8'h81, 1'b1);
        tick(20);
        checks += 3;
        if (rxq.size() != 1 || rxq[0] !== 8'h81) begin
            errors++; $display("FAIL rst_mid_byte: got %0d bytes first %h expected 1 byte 81", rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx);
        end
        if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_overflow: got %b expected 0", overflow); end
        if (fe_cnt != f0) begin errors++; $display("FAIL rst_mid_framing: got %0d pulses expected 0", fe_cnt - f0); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        logic [7:0] d;
        int v0, f0, p0;
        int unsigned start;
        d = 8'h07;
        rxq.delete();
        v0 = valid_cnt; f0 = fe_cnt; p0 = pe_cnt;
        start = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(1'b0);
        send_bit(1'b1);
        tick(30);
        checks += 4;
        if (pe_cnt - p0 != 1) begin errors++; $display("FAIL parity_pulse: got %0d cycles expected 1", pe_cnt - p0); end
        if (last_pe_cyc - start != LAT - CPB) begin errors++; $display("FAIL parity_latency: got %0d expected %0d", last_pe_cyc - start, LAT - CPB); end
        if (valid_cnt != v0) begin errors++; $display("FAIL parity_valid: got %0d cycles expected 0", valid_cnt - v0); end
        if (fe_cnt != f0) begin errors++; $display("FAIL parity_framing: got %0d pulses expected 0", fe_cnt - f0); end
    endtask
`endif

    initial begin
        reset        = 1'b1;
        uart_receive = 1'b1;
        out_ready    = 1'b1;
        tick(4);
        test_reset();
        reset = 1'b0;
        tick(5);
        test_single_frame();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
